// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM_ADR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_RTYPE_EX,
    S_RTYPE_WB,
    S_BEQ_EX,
    S_ADDI_EX,
    S_ADDI_WB,
    S_J_EX,
    S_ILLEGAL
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM4 = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

endpackage

// File: rtl/mips_mc_outdec.sv
// State-to-control-word decoder for the multi-cycle MIPS controller.
module mips_mc_outdec
  import mips_mc_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  input  logic   zero,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
        ctrl.pc_src    = PC_ALU;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM4;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_ADR, S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_RTYPE_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_RTYPE_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BEQ_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = PC_ALUOUT;
        ctrl.pc_write  = zero;
      end
      S_ADDI_WB: ctrl.reg_write = 1'b1;
      S_J_EX: begin
        ctrl.pc_src   = PC_JUMP;
        ctrl.pc_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath.
module mips_multicycle_ctrl
  import mips_mc_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int OP_W  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  state_t state;
  state_t next;
  ctrl_t  ctrl;

  always_comb begin
    next = S_IDLE;
    unique case (state)
      S_IDLE:   next = S_FETCH;
      S_FETCH:  next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_W'(OP_RTYPE): next = S_RTYPE_EX;
          OP_W'(OP_LW):    next = S_MEM_ADR;
          OP_W'(OP_SW):    next = S_MEM_ADR;
          OP_W'(OP_BEQ):   next = S_BEQ_EX;
          OP_W'(OP_ADDI):  next = S_ADDI_EX;
          OP_W'(OP_J):     next = S_J_EX;
          default:         next = S_ILLEGAL;
        endcase
      end
      S_MEM_ADR:
        next = (opcode == OP_W'(OP_LW)) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   next = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   next = mem_ready ? S_FETCH : S_MEM_WR;
      S_RTYPE_EX: next = S_RTYPE_WB;
      S_ADDI_EX:  next = S_ADDI_WB;
      S_MEM_WB, S_RTYPE_WB, S_ADDI_WB,
      S_BEQ_EX, S_J_EX:
        next = S_FETCH;
      S_ILLEGAL:  next = S_ILLEGAL;
      default:    next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      instr_count <= '0;
      illegal_op  <= 1'b0;
    end else begin
      state <= next;
      if (state == S_FETCH && mem_ready)
        instr_count <= instr_count + CNT_W'(1);
      if (next == S_ILLEGAL)
        illegal_op <= 1'b1;
    end
  end

  mips_mc_outdec u_outdec (
    .state     (state),
    .mem_ready (mem_ready),
    .zero      (zero),
    .ctrl      (ctrl)
  );

  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign iord       = ctrl.iord;
  assign ir_write   = ctrl.ir_write;
  assign pc_write   = ctrl.pc_write;
  assign pc_src     = ctrl.pc_src;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_write  = ctrl.reg_write;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed scoreboard bench for the multi-cycle MIPS controller.
module tb_mips_multicycle_ctrl;

  logic        clk;
  logic        reset;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        mem_read;
  logic        mem_write;
  logic        iord;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic        reg_dst;
  logic        mem_to_reg;
  logic        reg_write;
  logic        illegal_op;
  logic [31:0] instr_count;

  mips_multicycle_ctrl #(.CNT_W(32), .OP_W(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .iord        (iord),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .reg_write   (reg_write),
    .illegal_op  (illegal_op),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum {
    E_IDLE, E_FETCH, E_DECODE, E_MEM_ADR, E_MEM_RD, E_MEM_WB,
    E_MEM_WR, E_RTYPE_EX, E_RTYPE_WB, E_BEQ_EX, E_ADDI_EX,
    E_ADDI_WB, E_J_EX, E_ILLEGAL
  } est_t;

  typedef struct {
    logic [15:0] w;
    logic [31:0] c;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] ecnt = 0;

  localparam logic [5:0] RT  = 6'b000000;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] ADI = 6'b001000;
  localparam logic [5:0] JMP = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  // word order: rd wr iord irw pcw pcs[2] a b[2] op[2] dst m2r rw ill
  function automatic logic [15:0] cw(
    input logic mr, input logic mw, input logic io,
    input logic irw, input logic pcw, input logic [1:0] pcs,
    input logic asa, input logic [1:0] asb, input logic [1:0] aop,
    input logic rd, input logic m2r, input logic rw, input logic ill);
    return {mr, mw, io, irw, pcw, pcs, asa, asb, aop, rd, m2r, rw, ill};
  endfunction

  function automatic logic [15:0] expw(input est_t s, input logic b);
    case (s)
      E_FETCH:    return cw(1'b1, 1'b0, 1'b0, b, b, 2'b00, 1'b0, 2'b01,
                            2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      E_DECODE:   return cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0,
                            2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      E_MEM_ADR,
      E_ADDI_EX:  return cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1,
                            2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      E_MEM_RD:   return cw(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0,
                            2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      E_MEM_WB:   return cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0,
                            2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
      E_MEM_WR:   return cw(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0,
                            2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      E_RTYPE_EX: return cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1,
                            2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
      E_RTYPE_WB: return cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0,
                            2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
      E_BEQ_EX:   return cw(1'b0, 1'b0, 1'b0, 1'b0, b, 2'b01, 1'b1,
                            2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
      E_ADDI_WB:  return cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0,
                            2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
      E_J_EX:     return cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0,
                            2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      E_ILLEGAL:  return cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0,
                            2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
      default:    return '0;
    endcase
  endfunction

  task automatic check();
    exp_t        e;
    logic [15:0] got;
    e   = sb.pop_front();
    got = {mem_read, mem_write, iord, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg,
           reg_write, illegal_op};
    vectors++;
    assert (got === e.w) else begin
      miscompares++;
      $error("FAIL %s ctrl got=%h exp=%h", e.tag, got, e.w);
    end
    vectors++;
    assert (instr_count === e.c) else begin
      miscompares++;
      $error("FAIL %s count got=%0d exp=%0d", e.tag, instr_count, e.c);
    end
  endtask

  task automatic probe(input logic [15:0] w, input string tag);
    sb.push_back('{w, ecnt, tag});
    #1;
    check();
  endtask

  task automatic step(input logic mr, input logic z,
                      input logic [5:0] op, input est_t s,
                      input string tag);
    mem_ready = mr;
    zero      = z;
    opcode    = op;
    probe(expw(s, (s == E_FETCH) ? mr : z), tag);
    if (s == E_FETCH && mr)
      ecnt++;
    @(negedge clk);
  endtask

  task automatic fetch(input logic [5:0] op, input int waits);
    for (int i = 0; i < waits; i++)
      step(1'b0, 1'b0, op, E_FETCH, "fetch_wait");
    step(1'b1, 1'b0, op, E_FETCH, "fetch");
    step(1'($urandom_range(0, 1)), 1'b0, op, E_DECODE, "decode");
  endtask

  initial begin
    reset     = 1'b0;
    mem_ready = 1'b1;
    zero      = 1'b0;
    opcode    = RT;
    #3;
    probe('0, "in_reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 1'b0, RT, E_IDLE, "idle");

    fetch(RT, 0);
    step(1'b1, 1'b0, RT, E_RTYPE_EX, "rt_ex");
    step(1'b0, 1'b0, RT, E_RTYPE_WB, "rt_wb");

    fetch(LW, 0);
    step(1'b0, 1'b0, LW, E_MEM_ADR, "lw_adr");
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, LW, E_MEM_RD, "lw_wait");
    step(1'b1, 1'b0, LW, E_MEM_RD, "lw_rd");
    step(1'b1, 1'b0, LW, E_MEM_WB, "lw_wb");

    fetch(SW, 2);
    step(1'b1, 1'b0, SW, E_MEM_ADR, "sw_adr");
    step(1'b0, 1'b0, SW, E_MEM_WR, "sw_wait");
    step(1'b1, 1'b0, SW, E_MEM_WR, "sw_wr");

    fetch(BEQ, 0);
    step(1'b1, 1'b1, BEQ, E_BEQ_EX, "beq_taken");
    fetch(BEQ, 0);
    step(1'b1, 1'b0, BEQ, E_BEQ_EX, "beq_not");

    fetch(ADI, 1);
    step(1'b0, 1'b0, ADI, E_ADDI_EX, "addi_ex");
    step(1'b1, 1'b0, ADI, E_ADDI_WB, "addi_wb");

    fetch(JMP, 0);
    step(1'b0, 1'b0, JMP, E_J_EX, "j_ex");

    fetch(SW, 0);
    step(1'b1, 1'b0, SW, E_MEM_ADR, "sw2_adr");
    step(1'b0, 1'b0, SW, E_MEM_WR, "sw2_wait");
    probe(expw(E_MEM_WR, 1'b0), "sw2_hold");
    #2;
    reset = 1'b0;
    ecnt  = 0;
    probe('0, "wr_reset");
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 1'b0, RT, E_IDLE, "wr_idle");

    fetch(BAD, 0);
    for (int i = 0; i < 12; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           BAD, E_ILLEGAL, "illegal");
    reset = 1'b0;
    ecnt  = 0;
    probe('0, "ill_reset");
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 1'b0, RT, E_IDLE, "ill_idle");
    step(1'b1, 1'b0, RT, E_FETCH, "ill_fetch");
    step(1'b1, 1'b0, RT, E_DECODE, "ill_decode");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
